imem_loader: RTL

//  Hardware program loader: the write side of CPU program/start control. Receives a byte

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_word_packer.sv | 40 ++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and default geometry.
package imem_loader_pkg;
  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 8;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_DATA  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RUN   = 3'd4
  } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian bytes into 32-bit words; word_vld_o is combinational on the 4th byte.
// No backpressure of its own: it takes every byte_vld_i it is given.
module imem_word_packer (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_dat_i,
  output logic        word_vld_o,
  output logic [31:0] word_dat_o
);
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    idx_d   = idx_q;
    shreg_d = shreg_q;
    if (clr_i) begin
      idx_d   = 2'd0;
      shreg_d = 32'd0;
    end else if (byte_vld_i) begin
      idx_d   = idx_q + 2'd1;
      shreg_d = {byte_dat_i, shreg_q[31:8]};
    end
  end

  // First byte ends up in bits [7:0] after four right shifts.
  assign word_vld_o = byte_vld_i && (idx_q == 2'd3) && !clr_i;
  assign word_dat_o = {byte_dat_i, shreg_q[31:8]};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q   <= 2'd0;
      shreg_q <= 32'd0;
    end else begin
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Program loader: header + words -> imem write port, zero-fill, then hold start_o until reload.
// Writes lag the 4th byte by one cycle; in_ready_o drops outside HDR0/HDR1/DATA and in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  input  logic              reload_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              start_o,
  output logic              err_o
);
  localparam logic [LEN_W-1:0]  DEPTH_L   = LEN_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                start_q, start_d;
  logic                err_q, err_d;

  logic                xfer;
  logic                pk_clr;
  logic                word_vld;
  logic [31:0]         word_dat;
  logic [LEN_W-1:0]    hdr_cnt;
  logic [LEN_W-1:0]    wcnt_inc;

  assign in_ready_o = rst_n_i &&
                      (state_q == ST_HDR0 || state_q == ST_HDR1 || state_q == ST_DATA);
  assign xfer       = in_valid_i && in_ready_o;
  assign pk_clr     = (state_q == ST_RUN) && reload_i;
  assign hdr_cnt    = LEN_W'({in_data_i, cnt_q[7:0]});
  assign wcnt_inc   = wcnt_q + LEN_W'(1);

  imem_word_packer u_packer (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (pk_clr),
    .byte_vld_i (xfer && (state_q == ST_DATA)),
    .byte_dat_i (in_data_i),
    .word_vld_o (word_vld),
    .word_dat_o (word_dat)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    clr_addr_d = clr_addr_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    start_d    = 1'b0;
    err_d      = err_q;
    case (state_q)
      ST_HDR0: begin
        if (xfer) begin
          cnt_d[7:0] = in_data_i;
          state_d    = ST_HDR1;
        end
      end
      ST_HDR1: begin
        if (xfer) begin
          cnt_d      = hdr_cnt;
          err_d      = (hdr_cnt > DEPTH_L);
          wcnt_d     = '0;
          clr_addr_d = hdr_cnt[ADDR_W-1:0];
          state_d    = (hdr_cnt == '0) ? ST_CLEAR : ST_DATA;
        end
      end
      ST_DATA: begin
        if (word_vld) begin
          // Words past the end of memory are drained from the stream but dropped.
          if (wcnt_q < DEPTH_L) begin
            we_d    = 1'b1;
            addr_d  = wcnt_q[ADDR_W-1:0];
            wdata_d = word_dat;
          end
          wcnt_d = wcnt_inc;
          if (wcnt_inc == cnt_q) begin
            clr_addr_d = cnt_q[ADDR_W-1:0];
            state_d    = (cnt_q >= DEPTH_L) ? ST_RUN : ST_CLEAR;
          end
        end
      end
      ST_CLEAR: begin
        we_d       = 1'b1;
        addr_d     = clr_addr_q;
        wdata_d    = 32'd0;
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        start_d = 1'b1;
        if (reload_i) begin
          start_d = 1'b0;
          err_d   = 1'b0;
          state_d = ST_HDR0;
        end
      end
      default: state_d = ST_HDR0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_HDR0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      clr_addr_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      clr_addr_q <= clr_addr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      start_q    <= start_d;
      err_q      <= err_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign start_o      = start_q;
  assign err_o        = err_q;
endmodule
